// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared types and constants for the time-setting controller:
//               FSM state encoding, field widths, limits and wrap helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;

  localparam logic [HR_W-1:0]  MAX_HR  = 5'd23;
  localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_t;

  // Hour +1 with 23 -> 0 wrap; anything at or above the limit restarts at 0.
  function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] v);
    return (v >= MAX_HR) ? '0 : v + 5'd1;
  endfunction

  // Minute +1 with 59 -> 0 wrap.
  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] v);
    return (v >= MAX_MIN) ? '0 : v + 6'd1;
  endfunction

  // Out-of-range values from the time-of-day counter are captured as 0.
  function automatic logic [HR_W-1:0] hr_sanitize(input logic [HR_W-1:0] v);
    return (v > MAX_HR) ? '0 : v;
  endfunction

  function automatic logic [MIN_W-1:0] min_sanitize(input logic [MIN_W-1:0] v);
    return (v > MAX_MIN) ? '0 : v;
  endfunction

endpackage : clock_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Raw button conditioning: 2-FF synchronizer, debouncer that
//               accepts a new level after DB_CYCLES consecutive differing
//               samples, and a one-cycle press pulse on a debounced 0->1.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  // Counter runs 0..DB_CYCLES-1; the level flips on the DB_CYCLES-th sample.
  localparam int              CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: count samples that disagree with the accepted level; a sample
  // that agrees restarts the count. Press fires only on an accepted rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
      r_press <= r_sync2;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_press <= 1'b0;
    end
  end

  assign o_press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : Two-button time-setting controller. Mode steps RUN -> SET_HR
//               -> SET_MIN -> RUN (with a load strobe), inc bumps the field
//               being edited, and the edited field blinks via hr/min_blank.
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DB_CYCLES    = 1000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  output logic [HR_W-1:0]  set_hr,
  output logic [MIN_W-1:0] set_min,
  output logic             load,
  output logic             setting,
  output logic             hr_blank,
  output logic             min_blank
);

  localparam int              BL_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);

  logic w_mode_press;
  logic w_inc_press;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_capture;
  logic             w_inc_hr;
  logic             w_inc_min;
  logic             w_load_nxt;
  logic             w_blink_clr;

  logic [BL_W-1:0]  r_bcnt;
  logic [BL_W-1:0]  w_bcnt_nxt;
  logic             r_phase;
  logic             w_phase_nxt;

  logic [HR_W-1:0]  r_set_hr;
  logic [MIN_W-1:0] r_set_min;
  logic             r_load;
  logic             r_setting;
  logic             r_hr_blank;
  logic             r_min_blank;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_mode (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_mode),
    .o_press (w_mode_press)
  );

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_inc (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_inc),
    .o_press (w_inc_press)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and edit controls; mode is checked first so it wins over inc.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_inc_hr    = 1'b0;
    w_inc_min   = 1'b0;
    w_load_nxt  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mode_press) begin
          w_state_nxt = ST_SET_HR;
          w_capture   = 1'b1;
        end
      end
      ST_SET_HR: begin
        if (w_mode_press) begin
          w_state_nxt = ST_SET_MIN;
        end else if (w_inc_press) begin
          w_inc_hr = 1'b1;
        end
      end
      ST_SET_MIN: begin
        if (w_mode_press) begin
          w_state_nxt = ST_RUN;
          w_load_nxt  = 1'b1;
        end else if (w_inc_press) begin
          w_inc_min = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Blink restarts on any state change or accepted increment so freshly
  // entered or just-edited digits are shown immediately.
  assign w_blink_clr = (w_state_nxt != r_state) | w_inc_hr | w_inc_min;

  // Next blink counter / phase.
  always_comb begin
    w_bcnt_nxt  = r_bcnt;
    w_phase_nxt = r_phase;
    if ((w_state_nxt == ST_RUN) || w_blink_clr) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (r_bcnt == BL_MAX) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = ~r_phase;
    end else begin
      w_bcnt_nxt  = r_bcnt + 1'b1;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_bcnt  <= w_bcnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Edited time fields: change only on capture or increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set_hr  <= '0;
      r_set_min <= '0;
    end else if (w_capture) begin
      r_set_hr  <= hr_sanitize(cur_hr);
      r_set_min <= min_sanitize(cur_min);
    end else begin
      if (w_inc_hr) begin
        r_set_hr <= hr_inc(r_set_hr);
      end
      if (w_inc_min) begin
        r_set_min <= min_inc(r_set_min);
      end
    end
  end

  // Registered outputs decoded from next state so they align with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load      <= 1'b0;
      r_setting   <= 1'b0;
      r_hr_blank  <= 1'b0;
      r_min_blank <= 1'b0;
    end else begin
      r_load      <= w_load_nxt;
      r_setting   <= (w_state_nxt != ST_RUN);
      r_hr_blank  <= (w_state_nxt == ST_SET_HR) & w_phase_nxt;
      r_min_blank <= (w_state_nxt == ST_SET_MIN) & w_phase_nxt;
    end
  end

  assign set_hr    = r_set_hr;
  assign set_min   = r_set_min;
  assign load      = r_load;
  assign setting   = r_setting;
  assign hr_blank  = r_hr_blank;
  assign min_blank = r_min_blank;

endmodule : time_set_ctrl
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_ctrl
// Description : Self-checking bench for time_set_ctrl with DB_CYCLES=4 and
//               BLINK_CYCLES=8; behavioural model plus directed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

  localparam int DB    = 4;
  localparam int BLINK = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hr = 5'd10;
  logic [5:0] cur_min = 6'd30;
  logic [4:0] set_hr;
  logic [5:0] set_min;
  logic       load;
  logic       setting;
  logic       hr_blank;
  logic       min_blank;

  time_set_ctrl #(
    .DB_CYCLES    (DB),
    .BLINK_CYCLES (BLINK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .cur_hr    (cur_hr),
    .cur_min   (cur_min),
    .set_hr    (set_hr),
    .set_min   (set_min),
    .load      (load),
    .setting   (setting),
    .hr_blank  (hr_blank),
    .min_blank (min_blank)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int load_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = running, 1 = editing hours, 2 = editing minutes
  int cyc, t0, m_mode, m_hr, m_mn;
  bit m_load, pm, pi, lv_m, lv_i;
  bit hm[$];
  bit hi[$];
  bit sm[$];
  bit si[$];

  // True when the last DB synchronized samples all disagree with the level.
  function automatic bit all_differ(input bit q[$], input bit lvl);
    if (q.size() < DB) return 1'b0;
    for (int k = 0; k < DB; k++) begin
      if (q[q.size()-1-k] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    cyc = 0; t0 = 0; m_mode = 0; m_hr = 0; m_mn = 0;
    m_load = 0; pm = 0; pi = 0; lv_m = 0; lv_i = 0;
    hm.delete(); hi.delete(); sm.delete(); si.delete();
    hm.push_back(1'b0); hm.push_back(1'b0);
    hi.push_back(1'b0); hi.push_back(1'b0);
  endtask

  task automatic model_step();
    bit s;
    cyc++;
    m_load = 0;
    case (m_mode)
      0: if (pm) begin
           m_mode = 1; t0 = cyc;
           m_hr = (int'(cur_hr) > 23) ? 0 : int'(cur_hr);
           m_mn = (int'(cur_min) > 59) ? 0 : int'(cur_min);
         end
      1: if (pm) begin m_mode = 2; t0 = cyc; end
         else if (pi) begin m_hr = (m_hr + 1) % 24; t0 = cyc; end
      default: if (pm) begin m_mode = 0; m_load = 1; end
         else if (pi) begin m_mn = (m_mn + 1) % 60; t0 = cyc; end
    endcase
    // raw input reaches the debouncer two edges after it is sampled
    s = hm[hm.size()-2]; hm.push_back(btn_mode); sm.push_back(s);
    s = hi[hi.size()-2]; hi.push_back(btn_inc);  si.push_back(s);
    if (hm.size() > 32) void'(hm.pop_front());
    if (hi.size() > 32) void'(hi.pop_front());
    if (sm.size() > 32) void'(sm.pop_front());
    if (si.size() > 32) void'(si.pop_front());
    pm = 0; pi = 0;
    if (all_differ(sm, lv_m)) begin lv_m = !lv_m; pm = lv_m; end
    if (all_differ(si, lv_i)) begin lv_i = !lv_i; pi = lv_i; end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    int ph;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ph = ((cyc - t0) / BLINK) % 2;
        check("set_hr",    int'(set_hr),    m_hr);
        check("set_min",   int'(set_min),   m_mn);
        check("load",      int'(load),      int'(m_load));
        check("setting",   int'(setting),   int'(m_mode != 0));
        check("hr_blank",  int'(hr_blank),  int'(m_mode == 1 && ph == 1));
        check("min_blank", int'(min_blank), int'(m_mode == 2 && ph == 1));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (load) load_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input bit m, input bit i);
    if (m) btn_mode = 1'b1;
    if (i) btn_inc  = 1'b1;
    cyc_wait(10);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc_wait(10);
  endtask

  initial begin
    int n, lc0, changes;
    bit prev;
    chk_en = 1'b1;
    cyc_wait(3);
    check("rst_setting", int'(setting), 0);
    check("rst_set_hr",  int'(set_hr),  0);
    check("rst_load",    int'(load),    0);
    rst = 1'b0;
    cyc_wait(2);

    // Bounce then hold: one press, entry 7 edges after the hold begins.
    for (int i = 0; i < 10; i++) begin
      btn_mode = (i % 2 == 0);
      cyc_wait(2);
    end
    check("bounce_no_entry", int'(setting), 0);
    btn_mode = 1'b1;
    n = 0;
    while (n < 30) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (setting) break;
    end
    check("bounce_latency", n, 7);
    cyc_wait(20);
    check("bounce_held_setting", int'(setting), 1);
    check("bounce_cap_hr",  int'(set_hr),  10);
    check("bounce_cap_min", int'(set_min), 30);
    btn_mode = 1'b0;
    cyc_wait(10);
    press(1, 0);
    press(1, 0);
    check("bounce_back_run", int'(setting), 0);

    // Full edit with wraps on both fields.
    cur_hr = 5'd22; cur_min = 6'd58;
    lc0 = load_cnt;
    press(1, 0);
    check("edit_cap_hr",  int'(set_hr),  22);
    check("edit_cap_min", int'(set_min), 58);
    press(0, 1);
    press(0, 1);
    check("edit_hr_wrap", int'(set_hr), 0);
    press(1, 0);
    press(0, 1);
    press(0, 1);
    check("edit_min_wrap", int'(set_min), 0);
    press(1, 0);
    check("edit_one_load", load_cnt - lc0, 1);
    check("edit_final_hr",  int'(set_hr),  0);
    check("edit_final_min", int'(set_min), 0);
    check("edit_setting_off", int'(setting), 0);

    // Out-of-range capture.
    cur_hr = 5'd27; cur_min = 6'd63;
    press(1, 0);
    check("oor_hr",  int'(set_hr),  0);
    check("oor_min", int'(set_min), 0);
    check("oor_setting", int'(setting), 1);

    // Simultaneous mode + inc in SET_HR: mode wins.
    press(0, 1);
    check("sim_pre_hr", int'(set_hr), 1);
    press(1, 1);
    check("sim_setting", int'(setting), 1);
    check("sim_hr_kept", int'(set_hr), 1);
    check("sim_min_kept", int'(set_min), 0);

    // Blink while idle in SET_MIN: 4 toggles over 32 cycles, hours steady.
    cyc_wait(20);
    @(negedge clk);
    prev = min_blank;
    changes = 0;
    n = 0;
    repeat (32) begin
      @(negedge clk);
      if (min_blank != prev) changes++;
      if (hr_blank) n++;
      prev = min_blank;
    end
    check("blink_min_toggles", changes, 4);
    check("blink_hr_quiet", n, 0);
    #2;
    btn_inc = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (set_min != 6'd0) break;
    end
    check("blink_inc_min", int'(set_min), 1);
    check("blink_inc_visible", int'(min_blank), 0);
    #2;
    btn_inc = 1'b0;
    cyc_wait(20);

    // Reset in the middle of an edit: no load, idle afterwards.
    lc0 = load_cnt;
    rst = 1'b1;
    cyc_wait(3);
    check("mid_rst_setting", int'(setting), 0);
    check("mid_rst_hr",  int'(set_hr),  0);
    check("mid_rst_min", int'(set_min), 0);
    check("mid_rst_blank", int'(hr_blank) + int'(min_blank), 0);
    rst = 1'b0;
    cyc_wait(20);
    check("mid_rst_no_load", load_cnt - lc0, 0);
    press(0, 1);
    check("run_inc_ignored_min", int'(set_min), 0);
    check("run_inc_ignored_hr",  int'(set_hr),  0);
    check("run_inc_setting", int'(setting), 0);

    cyc_wait(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_time_set_ctrl
`default_nettype wire
